// File: rtl/phase_gen.sv
// Phase accumulator that pairs each accepted I/Q sample with the pre-increment phase, one cycle later.
// Optional phase dithering is compiled in with PHASE_GEN_DITHER_EN.
module phase_gen #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [ACC_WIDTH-1:0]   freq_word,
    input  logic                          freq_load,
    input  logic                          phase_clear,
    input  logic                          ivalid,
    input  logic signed [DATA_WIDTH-1:0]  idata_r,
    input  logic signed [DATA_WIDTH-1:0]  idata_i,
    output logic                          ovalid,
    output logic signed [DATA_WIDTH-1:0]  odata_r,
    output logic signed [DATA_WIDTH-1:0]  odata_i,
    output logic signed [PHASE_WIDTH-1:0] phase
);

    localparam int DITH_W = ACC_WIDTH - PHASE_WIDTH;

    logic signed [ACC_WIDTH-1:0]   freq_q, freq_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   acc_base;
    logic signed [ACC_WIDTH-1:0]   dither;
    logic                          ovalid_q, ovalid_d;
    logic signed [DATA_WIDTH-1:0]  odata_r_q, odata_r_d;
    logic signed [DATA_WIDTH-1:0]  odata_i_q, odata_i_d;
    logic signed [PHASE_WIDTH-1:0] phase_q, phase_d;

    // Top PHASE_WIDTH bits of the accumulator: a two's-complement fraction of one turn.
    function automatic logic signed [PHASE_WIDTH-1:0] trunc_phase(
        input logic signed [ACC_WIDTH-1:0] a
    );
        return a[ACC_WIDTH-1 -: PHASE_WIDTH];
    endfunction

`ifdef PHASE_GEN_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Low bits below the phase LSB, zero-extended to the accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] dither_ext(input logic [15:0] l);
        logic signed [ACC_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (i < DITH_W && i < 16) d[i] = l[i % 16];
        end
        return d;
    endfunction

    always_comb begin
        lfsr_d = lfsr_q;
        if (ivalid) lfsr_d = lfsr_next(lfsr_q);
        dither = dither_ext(lfsr_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign dither = '0;
`endif

    always_comb begin
        acc_base  = phase_clear ? '0 : acc_q;
        freq_d    = freq_load ? freq_word : freq_q;
        acc_d     = acc_q;
        ovalid_d  = ivalid;
        odata_r_d = odata_r_q;
        odata_i_d = odata_i_q;
        phase_d   = phase_q;
        if (ivalid) begin
            // The increment uses the register value from before any same-edge load.
            acc_d     = acc_base + freq_q;
            odata_r_d = idata_r;
            odata_i_d = idata_i;
            phase_d   = trunc_phase(acc_base + dither);
        end else if (phase_clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            freq_q    <= '0;
            acc_q     <= '0;
            ovalid_q  <= 1'b0;
            odata_r_q <= '0;
            odata_i_q <= '0;
            phase_q   <= '0;
        end else begin
            freq_q    <= freq_d;
            acc_q     <= acc_d;
            ovalid_q  <= ovalid_d;
            odata_r_q <= odata_r_d;
            odata_i_q <= odata_i_d;
            phase_q   <= phase_d;
        end
    end

    assign ovalid  = ovalid_q;
    assign odata_r = odata_r_q;
    assign odata_i = odata_i_q;
    assign phase   = phase_q;

endmodule
